regfile_wb_arbiter: RTL

- Controller for the 16x32 register bank. Shares the single write port (addr3/dato/enable) between two writeback requesters: ALU and memory load.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards.
- Redirects writes to the PC register onto a separate PC-update output instead of the bank.
- Sits between execute/memory stages and the register bank.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/wb_scoreboard.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank writeback controller.
package regfile_pkg;

   localparam int NREG   = 16;
   localparam int AW     = 4;
   localparam int DW     = 32;
   localparam int PC_REG = 15;

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [DW-1:0] word_t;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;

   // Number of set bits in a pending vector; result spans 0..NREG.
   function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, a registered
// population count, and the RAW hazard compare for the two decode sources.
module wb_scoreboard
   import regfile_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_valid_i,
   input  reg_addr_t     issue_rd_i,
   input  logic          clr_valid_i,
   input  reg_addr_t     clr_rd_i,
   input  logic          flush_i,
   input  reg_addr_t     rs1_i,
   input  reg_addr_t     rs2_i,
   input  logic          rs1_used_i,
   input  logic          rs2_used_i,
   output logic          stall_o,
   output logic [AW:0]   pending_cnt_o
);

   logic [NREG-1:0] pending_q, pending_d;
   logic [AW:0]     cnt_q, cnt_d;

   // Next pending vector: clear on writeback, then set on issue so a newer
   // producer of the same register wins; flush overrides everything.
   always_comb begin
      pending_d = pending_q;
      if (clr_valid_i) pending_d[clr_rd_i] = 1'b0;
      if (issue_valid_i) pending_d[issue_rd_i] = 1'b1;
      if (flush_i) pending_d = '0;
      cnt_d = popcount(pending_d);
   end

   // Scoreboard and its count register together so they never disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   // Hazard looks only at the registered bits, so it clears the cycle after
   // the writeback edge.
   always_comb begin
      stall_o = (rs1_used_i && pending_q[rs1_i]) || (rs2_used_i && pending_q[rs2_i]);
   end

   assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback controller for the 16x32 register bank: round-robin sharing of the
// single write port between ALU and load results, PC-write redirect, and the
// pending-write scoreboard used by decode for RAW stalls.
//
// last_grant | meaning
// -----------+----------------------------------------------
// GRANT_ALU  | ALU took the last transfer; MEM wins a tie
// GRANT_MEM  | MEM took the last transfer (reset); ALU wins a tie
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alu_valid,
   input  reg_addr_t     alu_rd,
   input  word_t         alu_data,
   output logic          alu_ready,
   input  logic          mem_valid,
   input  reg_addr_t     mem_rd,
   input  word_t         mem_data,
   output logic          mem_ready,
   input  logic          issue_valid,
   input  reg_addr_t     issue_rd,
   input  reg_addr_t     rs1,
   input  reg_addr_t     rs2,
   input  logic          rs1_used,
   input  logic          rs2_used,
   input  logic          flush,
   output logic          rf_enable,
   output reg_addr_t     rf_waddr,
   output word_t         rf_wdata,
   output logic          pc_wr_valid,
   output word_t         pc_wr_data,
   output logic          stall,
   output logic [AW:0]   pending_cnt
);

   grant_t    last_grant_q, last_grant_d;
   logic      xfer;
   reg_addr_t xfer_rd;
   word_t     xfer_data;
   logic      xfer_is_pc;

   logic      rf_enable_q, rf_enable_d;
   reg_addr_t rf_waddr_q, rf_waddr_d;
   word_t     rf_wdata_q, rf_wdata_d;
   logic      pc_wr_valid_q, pc_wr_valid_d;
   word_t     pc_wr_data_q, pc_wr_data_d;

   // Round-robin state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= GRANT_MEM;
      else        last_grant_q <= last_grant_d;
   end

   // Grants: a lone requester always wins; on a tie the one not served last.
   always_comb begin
      alu_ready = !flush && alu_valid && (!mem_valid || last_grant_q == GRANT_MEM);
      mem_ready = !flush && mem_valid && (!alu_valid || last_grant_q == GRANT_ALU);
      xfer       = alu_ready || mem_ready;
      xfer_rd    = alu_ready ? alu_rd   : mem_rd;
      xfer_data  = alu_ready ? alu_data : mem_data;
      xfer_is_pc = (xfer_rd == reg_addr_t'(PC_REG));
   end

   // Next grant history moves only when something is actually transferred.
   always_comb begin
      last_grant_d = last_grant_q;
      if (alu_ready)      last_grant_d = GRANT_ALU;
      else if (mem_ready) last_grant_d = GRANT_MEM;
   end

   // Route the granted write to the bank or to the PC-update port.
   always_comb begin
      rf_enable_d   = xfer && !xfer_is_pc;
      pc_wr_valid_d = xfer && xfer_is_pc;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      pc_wr_data_d  = pc_wr_data_q;
      if (rf_enable_d) begin
         rf_waddr_d = xfer_rd;
         rf_wdata_d = xfer_data;
      end
      if (pc_wr_valid_d) pc_wr_data_d = xfer_data;
   end

   // One-cycle write latency; reset drops any in-flight write immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_enable_q   <= 1'b0;
         rf_waddr_q    <= '0;
         rf_wdata_q    <= '0;
         pc_wr_valid_q <= 1'b0;
         pc_wr_data_q  <= '0;
      end else begin
         rf_enable_q   <= rf_enable_d;
         rf_waddr_q    <= rf_waddr_d;
         rf_wdata_q    <= rf_wdata_d;
         pc_wr_valid_q <= pc_wr_valid_d;
         pc_wr_data_q  <= pc_wr_data_d;
      end
   end

   assign rf_enable   = rf_enable_q;
   assign rf_waddr    = rf_waddr_q;
   assign rf_wdata    = rf_wdata_q;
   assign pc_wr_valid = pc_wr_valid_q;
   assign pc_wr_data  = pc_wr_data_q;

   wb_scoreboard u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .clr_valid_i   (xfer),
      .clr_rd_i      (xfer_rd),
      .flush_i       (flush),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .rs1_used_i    (rs1_used),
      .rs2_used_i    (rs2_used),
      .stall_o       (stall),
      .pending_cnt_o (pending_cnt)
   );

endmodule
